// File: rtl/bias_loader.sv
// bias_loader: packs pairs of 32-bit stream beats into 64-bit words and
// writes them to consecutive bias RAM addresses (mod 128) from a base.
module bias_loader #(
  parameter int IN_W   = 32,
  parameter int DATA_W = 2 * IN_W,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_num_words,
  input  logic [IN_W-1:0]   i_data,
  input  logic              i_data_vld,
  output logic              o_data_rdy,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1 << ADDR_W);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              half_q, half_d;
  logic [IN_W-1:0]   lo_q, lo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              err_q, err_d;

  logic pair_done;
  logic [CNT_W-1:0] cnt_inc;

  // A pair completes when the high-half beat is accepted in LOAD
  assign pair_done = (state_q == LOAD) && i_data_vld && half_q;
  assign cnt_inc   = cnt_q + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_start && i_num_words <= MAX_WORDS)
              state_d = (i_num_words == '0) ? DONE : LOAD;
      LOAD: if (pair_done && cnt_inc == num_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; ready comes straight from the state
  always_comb begin
    o_data_rdy = (state_q == LOAD);
    o_busy     = (state_q != IDLE);
    o_done     = (state_q == DONE);
  end

  // Datapath: latch job parameters, pack beats, stage the RAM write
  always_comb begin
    base_d = base_q;
    num_d  = num_q;
    cnt_d  = cnt_q;
    half_d = half_q;
    lo_d   = lo_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    err_d  = 1'b0;
    if (state_q == IDLE && i_start) begin
      base_d = i_base_addr;
      num_d  = i_num_words;
      cnt_d  = '0;
      half_d = 1'b0;
      err_d  = (i_num_words > MAX_WORDS);
    end else if (state_q == LOAD && i_data_vld) begin
      if (!half_q) begin
        lo_d   = i_data;
        half_d = 1'b1;
      end else begin
        half_d = 1'b0;
        we_d   = 1'b1;
        addr_d = base_q + cnt_q[ADDR_W-1:0];  // wraps mod 2**ADDR_W
        din_d  = {i_data, lo_q};
        cnt_d  = cnt_inc;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
      half_q <= 1'b0;
      lo_q   <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      num_q  <= num_d;
      cnt_q  <= cnt_d;
      half_q <= half_d;
      lo_q   <= lo_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      err_q  <= err_d;
    end
  end

  assign o_ram_en   = we_q;
  assign o_ram_we   = we_q;
  assign o_ram_addr = addr_q;
  assign o_ram_din  = din_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_bias_loader.sv
// Scoreboard bench for bias_loader: stimulus pushes expected RAM events,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_bias_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_start = 1'b0;
  logic [6:0]  i_base_addr = '0;
  logic [7:0]  i_num_words = '0;
  logic [31:0] i_data = '0;
  logic        i_data_vld = 1'b0;
  logic        o_data_rdy, o_ram_en, o_ram_we, o_busy, o_done, o_err;
  logic [6:0]  o_ram_addr;
  logic [63:0] o_ram_din;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          we;
    bit          done;
    bit          err;
    logic [6:0]  addr;
    logic [63:0] data;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_r;

  bias_loader dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_words(i_num_words), .i_data(i_data), .i_data_vld(i_data_vld),
    .o_data_rdy(o_data_rdy), .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with RAM/done/err activity must match the next expected event
  always @(negedge clk) begin
    if (rstn && (o_ram_we || o_ram_en || o_done || o_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: we=%0b done=%0b err=%0b addr=%0d, expected no activity",
                 o_ram_we, o_done, o_err, o_ram_addr);
      end else begin
        mon_r = exp_q.pop_front();
        chk("ram_we", 64'(o_ram_we), 64'(mon_r.we));
        chk("ram_en", 64'(o_ram_en), 64'(mon_r.we));
        chk("done", 64'(o_done), 64'(mon_r.done));
        chk("err", 64'(o_err), 64'(mon_r.err));
        if (mon_r.we) begin
          chk("ram_addr", 64'(o_ram_addr), 64'(mon_r.addr));
          chk("ram_din", o_ram_din, mon_r.data);
        end
      end
    end
  end

  task automatic start(input int base, input int n);
    i_start = 1'b1;
    i_base_addr = 7'(base);
    i_num_words = 8'(n);
    @(negedge clk);
    i_start = 1'b0;
    i_base_addr = 7'($urandom);
    i_num_words = 8'($urandom);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      i_data = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic send_beat(input logic [31:0] d);
    int t = 0;
    i_data = d;
    i_data_vld = 1'b1;
    while (o_data_rdy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got o_data_rdy=%b, expected 1 within 20 cycles", o_data_rdy);
    end
    @(negedge clk);
    i_data_vld = 1'b0;
    i_data = $urandom;
  endtask

  function automatic void push_write(input int base, input int w, input int n,
                                     input logic [31:0] lo, input logic [31:0] hi);
    rec_t r;
    r.we = 1'b1;
    r.done = (w == n - 1);
    r.err = 1'b0;
    r.addr = 7'((base + w) % 128);
    r.data = {hi, lo};
    exp_q.push_back(r);
  endfunction

  // One complete load; gap is the percent chance of idle cycles before a beat
  task automatic do_load(input int base, input int n, input int gap,
                         input bit busy_start, input bit seq_data);
    logic [31:0] b[$];
    for (int i = 0; i < 2 * n; i++) b.push_back(seq_data ? 32'(i + 1) : $urandom);
    for (int w = 0; w < n; w++) push_write(base, w, n, b[2*w], b[2*w+1]);
    start(base, n);
    for (int i = 0; i < 2 * n; i++) begin
      if (gap > 0 && $urandom_range(0, 99) < gap) idle($urandom_range(1, 3));
      if (busy_start && i == 3) start($urandom_range(0, 127), $urandom_range(1, 200));
      send_beat(b[i]);
      if (i % 2 == 1) chk("write_latency", 64'(o_ram_we), 64'd1);
      if (i == 2 * n - 1) begin
        chk("done_with_last_write", 64'(o_done), 64'd1);
        chk("rdy_low_in_done", 64'(o_data_rdy), 64'd0);
      end
    end
    @(negedge clk);
    chk("idle_after_done", 64'(o_busy), 64'd0);
  endtask

  initial begin
    rec_t r;
    logic [31:0] rb[4];
    #1;
    // Reset state
    chk("rst_rdy", 64'(o_data_rdy), 64'd0);
    chk("rst_we", 64'(o_ram_we), 64'd0);
    chk("rst_en", 64'(o_ram_en), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_addr", 64'(o_ram_addr), 64'd0);
    chk("rst_din", o_ram_din, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Basic load, back-to-back
    do_load(0, 4, 0, 1'b0, 1'b1);
    // Wrap-around
    do_load(126, 4, 0, 1'b0, 1'b0);
    // Backpressure: a gap before every beat, so pairs are split by stalls
    do_load(20, 4, 100, 1'b0, 1'b1);
    // Start while busy is ignored
    do_load(50, 4, 20, 1'b1, 1'b0);

    // Count 0: done pulse right after start, no writes
    r = '{we: 1'b0, done: 1'b1, err: 1'b0, addr: '0, data: '0};
    exp_q.push_back(r);
    start(7, 0);
    chk("cnt0_busy", 64'(o_busy), 64'd1);
    @(negedge clk);
    chk("cnt0_idle", 64'(o_busy), 64'd0);

    // Count 129: error pulse, stay idle
    r = '{we: 1'b0, done: 1'b0, err: 1'b1, addr: '0, data: '0};
    exp_q.push_back(r);
    start(0, 129);
    chk("err_rdy", 64'(o_data_rdy), 64'd0);
    chk("err_busy", 64'(o_busy), 64'd0);
    @(negedge clk);
    chk("err_rdy_later", 64'(o_data_rdy), 64'd0);

    // Full memory
    do_load(0, 128, 0, 1'b0, 1'b0);

    // Random loads
    for (int k = 0; k < 6; k++)
      do_load($urandom_range(0, 127), $urandom_range(1, 8), 30, k[0], 1'b0);

    // Reset mid-load after 3 beats: one write made, half pair dropped
    for (int i = 0; i < 4; i++) rb[i] = $urandom;
    push_write(5, 0, 4, rb[0], rb[1]);
    start(5, 4);
    send_beat(rb[0]);
    send_beat(rb[1]);
    chk("rst_case_write", 64'(o_ram_we), 64'd1);
    send_beat(rb[2]);
    rstn = 1'b0;
    #1;
    chk("midrst_rdy", 64'(o_data_rdy), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_we", 64'(o_ram_we), 64'd0);
    chk("midrst_addr", 64'(o_ram_addr), 64'd0);
    chk("midrst_din", o_ram_din, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_load(10, 2, 0, 1'b0, 1'b0);

    idle(5);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bias_loader.md
# bias_loader

Write-side counterpart of the bias read path: accepts bias data as a 32-bit valid/ready stream and writes it into the 128x64 bias memory through that memory's single write port. Every two accepted beats are packed into one 64-bit word and written to consecutive addresses, starting from a programmable base. The block sits between the host/DMA load path and the bias RAM, and releases the RAM to the read path once the load completes.

## Interface
- IN_W, 32, input stream beat width.
- DATA_W, 64, bias RAM word width; fixed at 2*IN_W.
- ADDR_W, 7, bias RAM address width (128 words).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- i_start  input  1  one-cycle load request; ignored unless the FSM is in IDLE.
- i_base_addr  input  ADDR_W  first RAM address, sampled on an accepted i_start.
- i_num_words  input  ADDR_W+1  number of 64-bit words to write, sampled with i_start; valid range 0..128.
- i_data  input  IN_W  stream beat.
- i_data_vld  input  1  beat valid.
- o_data_rdy  output  1  beat ready; a beat is transferred when i_data_vld & o_data_rdy.
- o_ram_en  output  1  RAM enable; driven with o_ram_we.
- o_ram_we  output  1  RAM write enable.
- o_ram_addr  output  ADDR_W  RAM write address.
- o_ram_din  output  DATA_W  RAM write data.
- o_busy  output  1  high in LOAD and DONE.
- o_done  output  1  one-cycle completion pulse.
- o_err  output  1  one-cycle pulse when i_start is accepted with i_num_words > 128.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - o_data_rdy = 0.
  - On i_start, latch base address and word count, clear the word counter and the half flag.
  - Count 0: go directly to DONE. No write is issued.
  - Count > 128: pulse o_err for one cycle, stay in IDLE, write nothing.
  - Otherwise: go to LOAD.
- LOAD:
  - o_data_rdy = 1, driven combinationally from the state.
  - Beat packing: the first beat of a pair goes to the low half, o_ram_din[31:0]. The second beat goes to the high half, o_ram_din[63:32].
  - When the second beat is accepted, the write registers load {beat1, beat0} and address base + word_cnt (mod 128). word_cnt then increments.
  - When the incremented count equals the latched count, the next state is DONE.
- DONE: lasts one cycle with o_done = 1, then returns to IDLE.
- Address generation wraps modulo 128. Example: base 126 with count 4 writes addresses 126, 127, 0, 1.
- i_start is ignored while in LOAD or DONE. No error is flagged for it.
- Beats with i_data_vld = 0 leave all state unchanged. A stalled stream may hold a half-filled pair indefinitely.

## Timing
- Reset values: FSM = IDLE; o_data_rdy, o_ram_en, o_ram_we, o_busy, o_done, o_err = 0; o_ram_addr = 0; o_ram_din = 0; counters = 0.
- i_start sampled at edge E0: LOAD from E0 onward, so o_data_rdy = 1 in the cycle after E0.
- Write latency:
  - Second beat of a pair accepted at edge Ek: o_ram_en = o_ram_we = 1 for exactly the one cycle following Ek, with address and data valid in that same cycle.
  - Otherwise o_ram_en and o_ram_we are 0.
- Throughput: one beat per cycle, so one RAM write every two cycles at full rate.
- Last pair accepted at edge En:
  - The final write and o_done are both high in the cycle after En (FSM = DONE).
  - o_data_rdy = 0 in that cycle.
  - IDLE follows at the next edge.
- Count 0: o_done is high in the cycle after the i_start edge, with no RAM activity.
- Reset asserted mid-load: all outputs return to their reset values immediately (asynchronous). The partial pair is discarded. RAM contents already written are left as-is.
- o_busy = (FSM != IDLE).

## Test plan
- Basic load: base 0, count 4, 8 back-to-back beats 0x00000001..0x00000008 -> writes at addresses 0..3 with data 0x0000000200000001, 0x0000000400000003, 0x0000000600000005, 0x0000000800000007; writes appear one cycle after each even beat; o_done is high in the same cycle as the address-3 write.
- Wrap-around: base 126, count 4 -> write addresses 126, 127, 0, 1; o_err stays 0.
- Backpressure and gaps: random i_data_vld gaps, including a stall between the two halves of a pair -> no spurious writes; packed data identical to the gap-free run; done only after the 4th write.
- Edge counts: count 0 -> o_done pulse one cycle after start, o_ram_we never asserted. Count 129 -> o_err pulse, FSM stays IDLE, o_data_rdy stays 0. Count 128 -> exactly 128 writes, with address 127 last when base is 0.
- Start while busy: i_start with new base/count pulsed mid-load -> ignored; the original load completes unchanged.
- Reset mid-load: rstn low after 3 beats -> all outputs 0 at once; after release, a fresh load at base 10 writes its first word at address 10 from the first two new beats, not the stale beat.
